pulse_to_level: RTL and testbench
=================================

// Module: pulse_to_level
// PURPOSE
//   Inverse of the level-to-pulse converter: turns single-cycle event pulses into a
//   level held high for a programmable number of clk cycles (pulse stretcher).
//   Used where a one-cycle strobe must drive a slower or level-sensitive consumer
//   (LED, slow-domain enable, interrupt line). Registered Mealy/Moore hybrid FSM.
// PARAMETERS
//   HOLD_CYCLES  8  cycles level stays high per accepted pulse (>=1)
//   GAP_CYCLES   2  dead cycles after level falls before next pulse accepted (>=0)
//   RETRIGGER    1  1: pulse during HOLD reloads hold count; 0: pulse dropped
//   CNT_W        8  width of event_count (only with PTL_EVENT_COUNT_EN)
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   pulse        in   1      event strobe; each high cycle sampled is one event
//   clear        in   1      synchronous abort; returns FSM to IDLE
//   level        out  1      stretched output level (registered)
//   busy         out  1      high in HOLD or GAP (registered)
//   missed       out  1      one-cycle flag: a pulse was dropped (registered)
//   event_count  out  CNT_W  accepted-pulse count (only with PTL_EVENT_COUNT_EN)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, level=0, busy=0, missed=0, count=0,
//     event_count=0. Outputs fall without waiting for clk.
//   - Internal down-counter, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
//   - IDLE: pulse=1 -> HOLD, load HOLD_CYCLES-1; level=1 from the next edge (latency 1).
//   - HOLD: level=1, busy=1; count decrements each cycle.
//       count==0 & no retrigger -> GAP (load GAP_CYCLES-1) or IDLE if GAP_CYCLES==0.
//       pulse & RETRIGGER=1 -> reload HOLD_CYCLES-1, stay HOLD (also at count==0).
//       pulse & RETRIGGER=0 -> missed=1 next cycle, count unaffected.
//   - GAP: level=0, busy=1; pulse -> missed=1, dropped (incl. last GAP cycle).
//       count==0 -> IDLE. Pulse the cycle after GAP ends (in IDLE) is accepted.
//   - Isolated pulse: level high exactly HOLD_CYCLES cycles, busy high
//     HOLD_CYCLES+GAP_CYCLES cycles.
//   - Held-high pulse input: every sampled high cycle is an event (continuous
//     retrigger with RETRIGGER=1; repeated missed with RETRIGGER=0).
//   - clear=1: highest synchronous priority; next edge state=IDLE, level=0,
//     busy=0, missed=0; pulse in same cycle ignored, not flagged missed.
//   - missed is a single-cycle flag; deasserts next cycle unless another drop.
//   - Illegal state encodings recover to IDLE with level=0.
// CONFIGURATION
//   PTL_EVENT_COUNT_EN defined: event_count port present; increments by 1 on every
//     accepted pulse (start or retrigger), saturates at 2^CNT_W-1, zeroed by
//     reset and clear. Dropped pulses not counted.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING (HOLD_CYCLES=8, GAP_CYCLES=2 unless stated)
//   1 reset=0 mid-run, no clk edge -> level,busy,missed=0 immediately; release, idle.
//   2 pulse one cycle at edge N -> level=1 edges N+1..N+8, busy=1 N+1..N+10, missed=0.
//   3 pulses at N and N+5 (RETRIGGER=1) -> level high 13 cycles continuously;
//     event_count=2 with PTL_EVENT_COUNT_EN.
//   4 RETRIGGER=0, pulses at N and N+5 -> missed=1 at N+6 only, level high 8 cycles.
//   5 pulse in GAP (N+9) -> missed=1 at N+10, no level; pulse at N+11 accepted.
//   6 clear during HOLD at N+3 -> level=0, busy=0 from N+4; next pulse gives full 8.

Source files
------------

// File: rtl/pulse_to_level.sv
// Pulse stretcher: each accepted one-cycle strobe holds `level` high for HOLD_CYCLES clocks,
// then a GAP_CYCLES dead time. Define PTL_EVENT_COUNT_EN to add the saturating event_count port.
module pulse_to_level #(
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2,
   parameter bit RETRIGGER   = 1'b1
`ifdef PTL_EVENT_COUNT_EN
   ,parameter int CNT_W      = 8
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse,
   input  logic clear,
   output logic level,
   output logic busy,
   output logic missed
`ifdef PTL_EVENT_COUNT_EN
   ,output logic [CNT_W-1:0] event_count
`endif
);

   localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW    = $clog2(MAX_C + 32'sd1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 32'sd1);
   localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 32'sd0) ? CW'(GAP_CYCLES - 32'sd1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HOLD = 2'b01,
      ST_GAP  = 2'b10
   } state_e;

   state_e          state_d, state_q;
   logic [CW-1:0]   cnt_d, cnt_q;
   logic            level_d, level_q;
   logic            busy_d, busy_q;
   logic            missed_d, missed_q;

   // Next-state, hold/gap counter and drop detection; clear overrides everything.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      missed_d = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pulse) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  cnt_d   = '0;
               end
            end
            ST_HOLD: begin
               if (pulse && RETRIGGER) begin
                  cnt_d = HOLD_LOAD;
               end else begin
                  missed_d = pulse;
                  if (cnt_q == '0) begin
                     if (GAP_CYCLES > 32'sd0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                     end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                     end
                  end else begin
                     cnt_d = cnt_q - CW'(1);
                  end
               end
            end
            ST_GAP: begin
               // A pulse is dropped even in the final dead cycle.
               missed_d = pulse;
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      level_d = (state_d == ST_HOLD);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         busy_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         busy_q   <= busy_d;
         missed_q <= missed_d;
      end
   end

   assign level  = level_q;
   assign busy   = busy_q;
   assign missed = missed_q;

`ifdef PTL_EVENT_COUNT_EN
   logic             accept_s;
   logic [CNT_W-1:0] event_count_d, event_count_q;

   // Saturating count of accepted pulses (starts and retriggers).
   always_comb begin
      accept_s = !clear && pulse &&
                 ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && RETRIGGER));
      if (clear) begin
         event_count_d = '0;
      end else if (accept_s && (event_count_q != {CNT_W{1'b1}})) begin
         event_count_d = event_count_q + CNT_W'(1);
      end else begin
         event_count_d = event_count_q;
      end
   end

   // Event counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         event_count_q <= '0;
      end else begin
         event_count_q <= event_count_d;
      end
   end

   assign event_count = event_count_q;
`endif

endmodule

// File: tb/tb_pulse_to_level.sv
// Bench for pulse_to_level: three configurations driven in parallel, checked every cycle against
// a remaining-cycles model, plus directed scenarios with hand-computed cycle counts.
module tb_pulse_to_level;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic pulse = 1'b0;
   logic clear = 1'b0;
   logic [2:0] lvl_s, bsy_s, mis_s;
`ifdef PTL_EVENT_COUNT_EN
   logic [7:0] ec_s [3];
`endif

   int checks = 0;
   int errors = 0;

   localparam int HH [3] = '{8, 8, 3};
   localparam int GG [3] = '{2, 2, 0};
   localparam int RR [3] = '{1, 0, 1};

   always #5 clk = ~clk;

   pulse_to_level #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIGGER(1'b1)) u_rt (
      .clk(clk), .reset(reset), .pulse(pulse), .clear(clear),
      .level(lvl_s[0]), .busy(bsy_s[0]), .missed(mis_s[0])
`ifdef PTL_EVENT_COUNT_EN
      , .event_count(ec_s[0])
`endif
   );
   pulse_to_level #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIGGER(1'b0)) u_nr (
      .clk(clk), .reset(reset), .pulse(pulse), .clear(clear),
      .level(lvl_s[1]), .busy(bsy_s[1]), .missed(mis_s[1])
`ifdef PTL_EVENT_COUNT_EN
      , .event_count(ec_s[1])
`endif
   );
   pulse_to_level #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .RETRIGGER(1'b1)) u_g0 (
      .clk(clk), .reset(reset), .pulse(pulse), .clear(clear),
      .level(lvl_s[2]), .busy(bsy_s[2]), .missed(mis_s[2])
`ifdef PTL_EVENT_COUNT_EN
      , .event_count(ec_s[2])
`endif
   );

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: hl = level cycles still to come, gl = dead cycles still to come.
   int hl [3];
   int gl [3];
   bit ms [3];
   int ec [3];

   always @(posedge clk or negedge reset) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset || clear) begin
            hl[i] = 0; gl[i] = 0; ms[i] = 1'b0; ec[i] = 0;
         end else if (hl[i] > 0) begin
            if (pulse && RR[i] == 1) begin
               hl[i] = HH[i]; ms[i] = 1'b0;
               if (ec[i] < 255) ec[i]++;
            end else begin
               ms[i] = pulse;
               hl[i]--;
               if (hl[i] == 0) gl[i] = GG[i];
            end
         end else if (gl[i] > 0) begin
            ms[i] = pulse;
            gl[i]--;
         end else begin
            ms[i] = 1'b0;
            if (pulse) begin
               hl[i] = HH[i];
               if (ec[i] < 255) ec[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         check($sformatf("level[%0d]", i), {31'b0, lvl_s[i]}, (hl[i] > 0) ? 1 : 0);
         check($sformatf("busy[%0d]", i), {31'b0, bsy_s[i]}, (hl[i] > 0 || gl[i] > 0) ? 1 : 0);
         check($sformatf("missed[%0d]", i), {31'b0, mis_s[i]}, ms[i] ? 1 : 0);
`ifdef PTL_EVENT_COUNT_EN
         check($sformatf("event_count[%0d]", i), {24'b0, ec_s[i]}, ec[i]);
`endif
      end
   end

   int lv_c [3];
   int bs_c [3];
   int ms_c [3];
   int ms_at [3];
   int rise_c [3];

   // Drive pulse/clear masks for n cycles; bit c is sampled at the c-th edge, outputs counted after it.
   task automatic burst(input logic [31:0] pm, input logic [31:0] cm, input int n);
      logic [2:0] prev;
      prev = lvl_s;
      for (int i = 0; i < 3; i++) begin
         lv_c[i] = 0; bs_c[i] = 0; ms_c[i] = 0; ms_at[i] = -1; rise_c[i] = 0;
      end
      for (int c = 0; c < n; c++) begin
         pulse = pm[c];
         clear = cm[c];
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            if (lvl_s[i]) lv_c[i]++;
            if (bsy_s[i]) bs_c[i]++;
            if (mis_s[i]) begin
               ms_c[i]++;
               if (ms_at[i] < 0) ms_at[i] = c;
            end
            if (lvl_s[i] && !prev[i]) rise_c[i]++;
         end
         prev = lvl_s;
      end
      pulse = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
`ifdef PTL_EVENT_COUNT_EN
      int ec0;
`endif
      #2;
      check("reset_level", {29'b0, lvl_s}, 0);
      check("reset_busy", {29'b0, bsy_s}, 0);
      check("reset_missed", {29'b0, mis_s}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Isolated pulse.
      burst(32'h0000_0001, 32'h0, 24);
      check("iso_level_rt", lv_c[0], 8);
      check("iso_busy_rt", bs_c[0], 10);
      check("iso_missed_rt", ms_c[0], 0);
      check("iso_level_nr", lv_c[1], 8);
      check("iso_level_g0", lv_c[2], 3);
      check("iso_busy_g0", bs_c[2], 3);

      // Second pulse five cycles into HOLD.
`ifdef PTL_EVENT_COUNT_EN
      ec0 = ec_s[0];
`endif
      burst(32'h0000_0021, 32'h0, 24);
      check("retrig_level_rt", lv_c[0], 13);
      check("retrig_rises_rt", rise_c[0], 1);
      check("retrig_missed_rt", ms_c[0], 0);
      check("noretrig_level_nr", lv_c[1], 8);
      check("noretrig_missed_cnt_nr", ms_c[1], 1);
      check("noretrig_missed_at_nr", ms_at[1], 5);
`ifdef PTL_EVENT_COUNT_EN
      check("retrig_count_rt", ec_s[0] - ec0, 2);
`endif

      // Pulse in the last dead cycle is dropped, the next one is accepted.
      burst(32'h0000_0C01, 32'h0, 24);
      check("gap_missed_cnt_rt", ms_c[0], 1);
      check("gap_missed_at_rt", ms_at[0], 10);
      check("gap_level_rt", lv_c[0], 16);
      check("gap_rises_rt", rise_c[0], 2);

      // Clear during HOLD with a simultaneous pulse, then a fresh pulse.
      burst(32'h0000_0029, 32'h0000_0008, 24);
      check("clear_level_rt", lv_c[0], 11);
      check("clear_busy_rt", bs_c[0], 13);
      check("clear_missed_rt", ms_c[0], 0);
      check("clear_missed_nr", ms_c[1], 0);

      // Asynchronous reset mid-HOLD, no clock edge needed.
      pulse = 1'b1;
      @(posedge clk); #1;
      pulse = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_level_rt", {31'b0, lvl_s[0]}, 1);
      #1 reset = 1'b0;
      #1;
      check("async_level", {29'b0, lvl_s}, 0);
      check("async_busy", {29'b0, bsy_s}, 0);
      check("async_missed", {29'b0, mis_s}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("post_reset_idle", {29'b0, bsy_s}, 0);

      // Random phases alternating sparse and dense pulse traffic.
      for (int i = 0; i < 3000; i++) begin
         if (((i / 250) % 2) == 0) begin
            pulse = ($urandom_range(0, 5) == 0);
         end else begin
            pulse = ($urandom_range(0, 3) != 0);
         end
         clear = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      pulse = 1'b0;
      clear = 1'b0;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
